// File: rtl/noc_vc_pkg.sv
// Shared NoC virtual-channel definitions: flit types, lock states,
// and small index helpers used by the tile link arbiters.
package noc_vc_pkg;

   localparam logic [1:0] PAYLOAD = 2'b00;
   localparam logic [1:0] HEAD    = 2'b01;
   localparam logic [1:0] TAIL    = 2'b10;
   localparam logic [1:0] SINGLE  = 2'b11;

   localparam int FLIT_MAX_W = 64;
   localparam int IDX_MAX_W  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } lock_state_e;

   // Type field sits in the two MSBs of a w-bit flit.
   function automatic logic [1:0] flit_type(
      input logic [FLIT_MAX_W-1:0] flit,
      input int unsigned           w
   );
      return 2'(flit >> (w - 2));
   endfunction

   function automatic logic [IDX_MAX_W-1:0] rr_next(
      input logic [IDX_MAX_W-1:0] idx,
      input int unsigned          n
   );
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin pick: first set request at or after
// start_i, wrapping; one-hot grant plus binary index.
module noc_rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o
);

   logic          hit_hi;
   logic          hit_lo;
   logic [IW-1:0] idx_hi;
   logic [IW-1:0] idx_lo;

   // hi covers [start, N), lo covers the wrapped part [0, start).
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && !hit_hi && (i >= int'(start_i))) begin
            hit_hi = 1'b1;
            idx_hi = IW'(i);
         end
         if (req_i[i] && !hit_lo && (i < int'(start_i))) begin
            hit_lo = 1'b1;
            idx_lo = IW'(i);
         end
      end
      gnt_idx_o = hit_hi ? idx_hi : idx_lo;
      gnt_oh_o  = '0;
      for (int i = 0; i < N; i++) begin
         gnt_oh_o[i] = (hit_hi | hit_lo) && (IW'(i) == gnt_idx_o);
      end
   end

endmodule

// File: rtl/noc_vc_link_arbiter.sv
// Packet-granular round-robin sharing of one NoC output link among VCs.
// Define NOC_VC_LINK_ARBITER_STATS_EN for per-VC flit/packet counters.
module noc_vc_link_arbiter
   import noc_vc_pkg::*;
#(
   parameter int noc_flit_data_width = 32,
   parameter int noc_flit_type_width = 2,
   parameter int vchannels           = 3
) (
   input  logic clk,
   input  logic rst_sys_n,
   input  logic [vchannels*(noc_flit_data_width+noc_flit_type_width)-1:0] in_flit,
   input  logic [vchannels-1:0] in_valid,
   output logic [vchannels-1:0] in_ready,
   output logic [noc_flit_data_width+noc_flit_type_width-1:0] noc_out_flit,
   output logic [vchannels-1:0] noc_out_valid,
   input  logic [vchannels-1:0] noc_out_ready
`ifdef NOC_VC_LINK_ARBITER_STATS_EN
   ,
   output logic [vchannels*32-1:0] stat_flits,
   output logic [vchannels*32-1:0] stat_pkts,
   output logic                    stat_proto_err
`endif
);

   localparam int unsigned FW = noc_flit_data_width + noc_flit_type_width;
   localparam int IW = (vchannels > 1) ? $clog2(vchannels) : 1;

   lock_state_e state_q, state_d;
   logic [IW-1:0] lock_vc_q, lock_vc_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;

   logic                 locked;
   logic [vchannels-1:0] pick_oh;
   logic [IW-1:0]        pick_idx;
   logic [vchannels-1:0] gnt_oh;
   logic [IW-1:0]        gnt_idx;
   logic [vchannels-1:0] xfer_vec;
   logic                 xfer;
   logic [FW-1:0]        cur_flit;
   logic [1:0]           cur_type;

   noc_rr_pick #(
      .N  (vchannels),
      .IW (IW)
   ) u_pick (
      .req_i     (in_valid),
      .start_i   (rr_ptr_q),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx)
   );

   // A locked link stays with lock_vc even when it has nothing to send.
   always_comb begin
      locked  = (state_q == ST_PKT);
      gnt_oh  = pick_oh;
      gnt_idx = pick_idx;
      if (locked) begin
         gnt_idx = lock_vc_q;
         for (int i = 0; i < vchannels; i++) begin
            gnt_oh[i] = (IW'(i) == lock_vc_q);
         end
      end
   end

   always_comb begin
      cur_flit = in_flit[FW-1:0];
      for (int i = 0; i < vchannels; i++) begin
         if (gnt_oh[i]) cur_flit = in_flit[i*FW +: FW];
      end
   end

   assign noc_out_flit  = cur_flit;
   assign noc_out_valid = gnt_oh & in_valid;
   assign in_ready      = gnt_oh & noc_out_ready;
   assign xfer_vec      = noc_out_valid & noc_out_ready;
   assign xfer          = |xfer_vec;
   assign cur_type      = flit_type(FLIT_MAX_W'(cur_flit), FW);

   always_comb begin
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      rr_ptr_d  = rr_ptr_q;
      if (xfer) begin
         unique case (state_q)
            ST_IDLE: begin
               if (cur_type == HEAD) begin
                  state_d   = ST_PKT;
                  lock_vc_d = gnt_idx;
               end else begin
                  rr_ptr_d = IW'(rr_next(3'(gnt_idx), vchannels));
               end
            end
            ST_PKT: begin
               if ((cur_type == TAIL) || (cur_type == SINGLE)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = IW'(rr_next(3'(lock_vc_q), vchannels));
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q   <= ST_IDLE;
         lock_vc_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

`ifdef NOC_VC_LINK_ARBITER_STATS_EN
   logic [vchannels-1:0][31:0] stat_flits_q, stat_flits_d;
   logic [vchannels-1:0][31:0] stat_pkts_q, stat_pkts_d;
   logic                       stat_proto_err_q, stat_proto_err_d;
   logic                       proto_err;

   always_comb begin
      proto_err = 1'b0;
      if (xfer) begin
         if (!locked) proto_err = (cur_type == PAYLOAD) || (cur_type == TAIL);
         else         proto_err = (cur_type == HEAD);
      end
      stat_proto_err_d = stat_proto_err_q | proto_err;
      stat_flits_d     = stat_flits_q;
      stat_pkts_d      = stat_pkts_q;
      for (int i = 0; i < vchannels; i++) begin
         if (xfer_vec[i]) begin
            stat_flits_d[i] = stat_flits_q[i] + 32'd1;
            if ((cur_type == TAIL) || (cur_type == SINGLE)) begin
               stat_pkts_d[i] = stat_pkts_q[i] + 32'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         stat_flits_q     <= '0;
         stat_pkts_q      <= '0;
         stat_proto_err_q <= 1'b0;
      end else begin
         stat_flits_q     <= stat_flits_d;
         stat_pkts_q      <= stat_pkts_d;
         stat_proto_err_q <= stat_proto_err_d;
      end
   end

   assign stat_flits     = stat_flits_q;
   assign stat_pkts      = stat_pkts_q;
   assign stat_proto_err = stat_proto_err_q;
`endif

endmodule
